// File: rtl/serial_parity_checker.sv
// Serial parity checker: DATA_W data bits (LSB first) then one parity bit per frame.
// Reports the recovered word, a per-frame parity error pulse and a saturating error count.
module serial_parity_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              odd_mode,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned IW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              rx;
  logic              mode;
  logic              last_data;
  logic              err_nxt;

  assign last_data = (bit_idx == IW'(DATA_W - 1));
  // Running XOR of the data bits, folded with the parity bit and the latched mode.
  assign err_nxt   = rx ^ bit_in ^ mode;

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (bit_valid) begin
      case (state)
        IDLE:    state_nxt = (DATA_W == 1) ? PARITY : DATA;
        DATA:    if (last_data) state_nxt = PARITY;
        PARITY:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx    <= '0;
      shreg      <= '0;
      rx         <= 1'b0;
      mode       <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      err_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      busy       <= (state_nxt != IDLE);
      if (clear) begin
        bit_idx <= '0;
        rx      <= 1'b0;
        err_cnt <= '0;
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            shreg   <= DATA_W'(bit_in);
            rx      <= bit_in;
            mode    <= odd_mode;
            bit_idx <= IW'(1);
          end
          DATA: begin
            shreg   <= shreg | (DATA_W'(bit_in) << bit_idx);
            rx      <= rx ^ bit_in;
            bit_idx <= bit_idx + IW'(1);
          end
          PARITY: begin
            data_out   <= shreg;
            frame_done <= 1'b1;
            parity_err <= err_nxt;
            if (err_nxt && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            bit_idx    <= '0;
            rx         <= 1'b0;
          end
          default: begin
            bit_idx <= '0;
            rx      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
